// File: rtl/rv_pkg.sv
// Shared RV decode definitions: opcodes, instruction field positions and the
// operand/destination usage functions for the register-file scoreboard.
package rv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 32;
  localparam int unsigned OPW  = 7;

  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned RD_LSB  = 7;
  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS2_LSB = 20;

  typedef logic [OPW-1:0] opcode_t;
  typedef logic [AW-1:0]  reg_addr_t;

  localparam opcode_t OP_LUI    = 7'b0110111;
  localparam opcode_t OP_AUIPC  = 7'b0010111;
  localparam opcode_t OP_JAL    = 7'b1101111;
  localparam opcode_t OP_JALR   = 7'b1100111;
  localparam opcode_t OP_LOAD   = 7'b0000011;
  localparam opcode_t OP_STORE  = 7'b0100011;
  localparam opcode_t OP_BRANCH = 7'b1100011;
  localparam opcode_t OP_REG    = 7'b0110011;
  localparam opcode_t OP_IMM    = 7'b0010011;

  // Register-relevant fields of a decoded instruction.
  typedef struct packed {
    reg_addr_t rs2;
    reg_addr_t rs1;
    reg_addr_t rd;
    opcode_t   op;
  } dec_fields_t;

  function automatic logic use_rs1(input opcode_t op);
    return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  endfunction

  function automatic logic use_rs2(input opcode_t op);
    return (op == OP_REG || op == OP_STORE || op == OP_BRANCH);
  endfunction

  function automatic logic has_rd(input opcode_t op, input reg_addr_t rd);
    return !(op == OP_STORE || op == OP_BRANCH || rd == '0);
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode / execute / writeback signal bundle of the scoreboarded register file.
interface regfile_sb_if;
  import rv_pkg::*;

  logic            wb_v;
  reg_addr_t       wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            dec_v;
  logic [XLEN-1:0] dec_ir;
  logic            dec_r;
  logic            ex_stall;
  logic            ex_v;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            wb_err;

  modport slave (
    input  wb_v, wb_addr, wb_data, dec_v, dec_ir, ex_stall,
    output dec_r, ex_v, rs1_data, rs2_data, wb_err
  );

  modport master (
    output wb_v, wb_addr, wb_data, dec_v, dec_ir, ex_stall,
    input  dec_r, ex_v, rs1_data, rs2_data, wb_err
  );
endinterface

// File: rtl/regfile_array.sv
// 32 x 32 architectural register storage: one write port, two asynchronous
// read ports, x0 reads as zero.
module regfile_array
  import rv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  reg_addr_t       waddr,
  input  logic [XLEN-1:0] wdata,
  input  reg_addr_t       raddr1,
  output logic [XLEN-1:0] rdata1_c,
  input  reg_addr_t       raddr2,
  output logic [XLEN-1:0] rdata2_c
);

  logic [XLEN-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && waddr != '0) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1_c = (raddr1 == '0) ? '0 : mem[raddr1];
  assign rdata2_c = (raddr2 == '0) ? '0 : mem[raddr2];

endmodule

// File: rtl/regfile_sb.sv
// Scoreboarded register file between decode and execute; stalls decode on RAW
// hazards until writeback retires. Define WB_BYPASS_EN to forward wb_data.
module regfile_sb
  import rv_pkg::*;
#(
  parameter int unsigned PEND_W = 2
) (
  input logic         clk,
  input logic         rst_n,
  regfile_sb_if.slave bus
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  dec_fields_t       f;
  logic [PEND_W-1:0] cnt [NREG];
  logic [PEND_W-1:0] eff1, eff2;
  logic [XLEN-1:0]   rd1_c, rd2_c;
  logic [XLEN-1:0]   opnd1, opnd2;
  logic [NREG-1:0]   inc_vec, dec_vec;
  logic              busy1, busy2, rd_full, fire, wb_we, hit1, hit2, has_rd_w;
  logic              unused_ir;

  assign f.op  = bus.dec_ir[OPC_LSB +: OPW];
  assign f.rd  = bus.dec_ir[RD_LSB  +: AW];
  assign f.rs1 = bus.dec_ir[RS1_LSB +: AW];
  assign f.rs2 = bus.dec_ir[RS2_LSB +: AW];
  assign unused_ir = ^{bus.dec_ir[31:25], bus.dec_ir[14:12]};

  regfile_array u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (wb_we),
    .waddr    (bus.wb_addr),
    .wdata    (bus.wb_data),
    .raddr1   (f.rs1),
    .rdata1_c (rd1_c),
    .raddr2   (f.rs2),
    .rdata2_c (rd2_c)
  );

  // Hazard detection and issue handshake.
  always_comb begin
    wb_we    = bus.wb_v && bus.wb_addr != '0;
    hit1     = wb_we && bus.wb_addr == f.rs1;
    hit2     = wb_we && bus.wb_addr == f.rs2;
    has_rd_w = has_rd(f.op, f.rd);
`ifdef WB_BYPASS_EN
    eff1  = cnt[f.rs1] - PEND_W'(hit1);
    eff2  = cnt[f.rs2] - PEND_W'(hit2);
    opnd1 = hit1 ? bus.wb_data : rd1_c;
    opnd2 = hit2 ? bus.wb_data : rd2_c;
`else
    eff1  = cnt[f.rs1];
    eff2  = cnt[f.rs2];
    opnd1 = rd1_c;
    opnd2 = rd2_c;
`endif
    busy1     = f.rs1 != '0 && eff1 != '0;
    busy2     = f.rs2 != '0 && eff2 != '0;
    rd_full   = has_rd_w && cnt[f.rd] == CNT_MAX;
    bus.dec_r = !bus.ex_stall && !(use_rs1(f.op) && busy1)
              && !(use_rs2(f.op) && busy2) && !rd_full;
    fire      = bus.dec_v && bus.dec_r;
  end

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      inc_vec[r] = fire && has_rd_w && f.rd == AW'(r);
      dec_vec[r] = bus.wb_v && bus.wb_addr == AW'(r);
    end
  end

  // Pending-write counters; a retire with nothing pending never underflows.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREG; r++) cnt[r] <= '0;
      bus.wb_err <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        if (inc_vec[r] && !dec_vec[r]) begin
          cnt[r] <= cnt[r] + PEND_W'(1);
        end else if (dec_vec[r] && !inc_vec[r] && cnt[r] != '0) begin
          cnt[r] <= cnt[r] - PEND_W'(1);
        end
      end
      if (wb_we && cnt[bus.wb_addr] == '0) bus.wb_err <= 1'b1;
    end
  end

  // Operand registers toward execute; frozen while execute stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.ex_v     <= 1'b0;
      bus.rs1_data <= '0;
      bus.rs2_data <= '0;
    end else if (!bus.ex_stall) begin
      bus.ex_v <= fire;
      if (fire) begin
        bus.rs1_data <= opnd1;
        bus.rs2_data <= opnd2;
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (expectations follow WB_BYPASS_EN).
module tb_regfile_sb;
  import rv_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  regfile_sb_if bus ();

  regfile_sb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input opcode_t op, input reg_addr_t rd,
                                     input reg_addr_t rs1, input reg_addr_t rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wb_v = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.dec_v = 1'b0; bus.dec_ir = '0; bus.ex_stall = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    tick(); tick();
    vectors++; if (bus.ex_v !== 1'b0) begin miscompares++; $display("FAIL reset_ex_v: got %b want 0", bus.ex_v); end
    vectors++; if (bus.rs1_data !== 32'h0) begin miscompares++; $display("FAIL reset_rs1: got %h want 0", bus.rs1_data); end
    vectors++; if (bus.rs2_data !== 32'h0) begin miscompares++; $display("FAIL reset_rs2: got %h want 0", bus.rs2_data); end
    vectors++; if (bus.wb_err !== 1'b0) begin miscompares++; $display("FAIL reset_wb_err: got %b want 0", bus.wb_err); end
    vectors++; if (bus.dec_r !== 1'b1) begin miscompares++; $display("FAIL reset_dec_r: got %b want 1", bus.dec_r); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_wb_err();
    bus.wb_v = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEADBEEF;
    tick();
    bus.wb_v = 1'b0;
    vectors++; if (bus.wb_err !== 1'b1) begin miscompares++; $display("FAIL wb_err_set: got %b want 1", bus.wb_err); end
    bus.dec_v = 1'b1; bus.dec_ir = mk(OP_STORE, 5'd0, 5'd5, 5'd5);
    #1;
    vectors++; if (bus.dec_r !== 1'b1) begin miscompares++; $display("FAIL wb_err_no_underflow: got %b want 1", bus.dec_r); end
    tick();
    bus.dec_v = 1'b0;
    vectors++; if (bus.ex_v !== 1'b1) begin miscompares++; $display("FAIL wb_err_ex_v: got %b want 1", bus.ex_v); end
    vectors++; if (bus.rs1_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL wb_err_rs1: got %h want deadbeef", bus.rs1_data); end
    vectors++; if (bus.rs2_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL wb_err_rs2: got %h want deadbeef", bus.rs2_data); end
    tick();
    vectors++; if (bus.ex_v !== 1'b0) begin miscompares++; $display("FAIL wb_err_ex_v_drop: got %b want 0", bus.ex_v); end
  endtask

  task automatic test_raw();
    bus.dec_v = 1'b1; bus.dec_ir = mk(OP_IMM, 5'd3, 5'd0, 5'd0);
    #1;
    vectors++; if (bus.dec_r !== 1'b1) begin miscompares++; $display("FAIL raw_addi_ready: got %b want 1", bus.dec_r); end
    tick();
    bus.dec_ir = mk(OP_REG, 5'd4, 5'd3, 5'd3);
    #1;
    vectors++; if (bus.dec_r !== 1'b0) begin miscompares++; $display("FAIL raw_add_stall1: got %b want 0", bus.dec_r); end
    vectors++; if (bus.ex_v !== 1'b1) begin miscompares++; $display("FAIL raw_addi_ex_v: got %b want 1", bus.ex_v); end
    tick();
    vectors++; if (bus.dec_r !== 1'b0) begin miscompares++; $display("FAIL raw_add_stall2: got %b want 0", bus.dec_r); end
    vectors++; if (bus.ex_v !== 1'b0) begin miscompares++; $display("FAIL raw_bubble_ex_v: got %b want 0", bus.ex_v); end
    bus.wb_v = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'd7;
    #1;
`ifdef WB_BYPASS_EN
    vectors++; if (bus.dec_r !== 1'b1) begin miscompares++; $display("FAIL raw_bypass_ready: got %b want 1", bus.dec_r); end
    tick();
    bus.wb_v = 1'b0; bus.dec_v = 1'b0;
`else
    vectors++; if (bus.dec_r !== 1'b0) begin miscompares++; $display("FAIL raw_wb_cycle_ready: got %b want 0", bus.dec_r); end
    tick();
    bus.wb_v = 1'b0;
    #1;
    vectors++; if (bus.dec_r !== 1'b1) begin miscompares++; $display("FAIL raw_after_wb_ready: got %b want 1", bus.dec_r); end
    tick();
    bus.dec_v = 1'b0;
`endif
    vectors++; if (bus.ex_v !== 1'b1) begin miscompares++; $display("FAIL raw_add_ex_v: got %b want 1", bus.ex_v); end
    vectors++; if (bus.rs1_data !== 32'd7) begin miscompares++; $display("FAIL raw_add_rs1: got %h want 7", bus.rs1_data); end
    vectors++; if (bus.rs2_data !== 32'd7) begin miscompares++; $display("FAIL raw_add_rs2: got %h want 7", bus.rs2_data); end
    bus.wb_v = 1'b1; bus.wb_addr = 5'd4; bus.wb_data = 32'd0;
    tick();
    bus.wb_v = 1'b0;
    tick();
  endtask

  task automatic test_x0();
    bus.wb_v = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'h1234;
    tick();
    bus.wb_v = 1'b0;
    bus.dec_v = 1'b1; bus.dec_ir = mk(OP_STORE, 5'd0, 5'd0, 5'd0);
    #1;
    vectors++; if (bus.dec_r !== 1'b1) begin miscompares++; $display("FAIL x0_ready: got %b want 1", bus.dec_r); end
    tick();
    bus.dec_v = 1'b0;
    vectors++; if (bus.rs1_data !== 32'h0) begin miscompares++; $display("FAIL x0_rs1: got %h want 0", bus.rs1_data); end
    vectors++; if (bus.rs2_data !== 32'h0) begin miscompares++; $display("FAIL x0_rs2: got %h want 0", bus.rs2_data); end
    tick();
  endtask

  task automatic test_saturate();
    bus.dec_v = 1'b1; bus.dec_ir = mk(OP_IMM, 5'd9, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (bus.dec_r !== 1'b1) begin miscompares++; $display("FAIL sat_issue%0d: got %b want 1", i, bus.dec_r); end
      tick();
    end
    vectors++; if (bus.dec_r !== 1'b0) begin miscompares++; $display("FAIL sat_full: got %b want 0", bus.dec_r); end
    bus.wb_v = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'h99;
    #1;
    vectors++; if (bus.dec_r !== 1'b0) begin miscompares++; $display("FAIL sat_full_wb_cycle: got %b want 0", bus.dec_r); end
    tick();
    bus.wb_v = 1'b0;
    #1;
    vectors++; if (bus.dec_r !== 1'b1) begin miscompares++; $display("FAIL sat_after_retire: got %b want 1", bus.dec_r); end
    tick();
    vectors++; if (bus.dec_r !== 1'b0) begin miscompares++; $display("FAIL sat_refull: got %b want 0", bus.dec_r); end
    bus.dec_v = 1'b0;
    bus.wb_v = 1'b1;
    tick(); tick(); tick();
    bus.wb_v = 1'b0;
    bus.dec_v = 1'b1; bus.dec_ir = mk(OP_STORE, 5'd0, 5'd9, 5'd0);
    #1;
    vectors++; if (bus.dec_r !== 1'b1) begin miscompares++; $display("FAIL sat_drained: got %b want 1", bus.dec_r); end
    bus.dec_v = 1'b0;
    tick();
  endtask

  task automatic test_inc_dec();
    bus.dec_v = 1'b1; bus.dec_ir = mk(OP_IMM, 5'd6, 5'd0, 5'd0);
    #1;
    vectors++; if (bus.dec_r !== 1'b1) begin miscompares++; $display("FAIL incdec_first: got %b want 1", bus.dec_r); end
    tick();
    bus.wb_v = 1'b1; bus.wb_addr = 5'd6; bus.wb_data = 32'h66;
    #1;
    vectors++; if (bus.dec_r !== 1'b1) begin miscompares++; $display("FAIL incdec_same_cycle: got %b want 1", bus.dec_r); end
    tick();
    bus.wb_v = 1'b0;
    bus.dec_ir = mk(OP_STORE, 5'd0, 5'd6, 5'd0);
    #1;
    vectors++; if (bus.dec_r !== 1'b0) begin miscompares++; $display("FAIL incdec_still_busy: got %b want 0", bus.dec_r); end
    bus.dec_v = 1'b0; bus.wb_v = 1'b1;
    tick();
    bus.wb_v = 1'b0; bus.dec_v = 1'b1;
    #1;
    vectors++; if (bus.dec_r !== 1'b1) begin miscompares++; $display("FAIL incdec_released: got %b want 1", bus.dec_r); end
    bus.dec_v = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    bus.wb_v = 1'b1; bus.wb_addr = 5'd10; bus.wb_data = 32'hA5;
    tick();
    bus.wb_v = 1'b0;
    bus.dec_v = 1'b1; bus.dec_ir = mk(OP_STORE, 5'd0, 5'd10, 5'd0);
    tick();
    bus.ex_stall = 1'b1; bus.dec_ir = mk(OP_STORE, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (bus.dec_r !== 1'b0) begin miscompares++; $display("FAIL stall_dec_r%0d: got %b want 0", i, bus.dec_r); end
      vectors++; if (bus.ex_v !== 1'b1) begin miscompares++; $display("FAIL stall_ex_v%0d: got %b want 1", i, bus.ex_v); end
      vectors++; if (bus.rs1_data !== 32'hA5) begin miscompares++; $display("FAIL stall_rs1_%0d: got %h want a5", i, bus.rs1_data); end
    end
    bus.ex_stall = 1'b0; bus.dec_v = 1'b0;
    tick();
    vectors++; if (bus.ex_v !== 1'b0) begin miscompares++; $display("FAIL stall_release_ex_v: got %b want 0", bus.ex_v); end
    vectors++; if (bus.rs1_data !== 32'hA5) begin miscompares++; $display("FAIL stall_release_rs1: got %h want a5", bus.rs1_data); end
  endtask

  task automatic test_mid_reset();
    bus.dec_v = 1'b1; bus.dec_ir = mk(OP_IMM, 5'd12, 5'd0, 5'd0);
    tick();
    bus.dec_v = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    vectors++; if (bus.ex_v !== 1'b0) begin miscompares++; $display("FAIL mid_reset_ex_v: got %b want 0", bus.ex_v); end
    vectors++; if (bus.wb_err !== 1'b0) begin miscompares++; $display("FAIL mid_reset_wb_err: got %b want 0", bus.wb_err); end
    bus.dec_v = 1'b1; bus.dec_ir = mk(OP_STORE, 5'd0, 5'd5, 5'd12);
    #1;
    vectors++; if (bus.dec_r !== 1'b1) begin miscompares++; $display("FAIL mid_reset_cnt_clear: got %b want 1", bus.dec_r); end
    tick();
    bus.dec_v = 1'b0;
    vectors++; if (bus.rs1_data !== 32'h0) begin miscompares++; $display("FAIL mid_reset_reg_clear: got %h want 0", bus.rs1_data); end
    tick();
  endtask

  initial begin
    test_reset();
    test_wb_err();
    test_raw();
    test_x0();
    test_saturate();
    test_inc_dec();
    test_stall();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
